// File: rtl/cmp_scan_driver.sv
// Scan sequencer for an inverting 8-bit equality comparator: steps a probe byte from base to limit and reports the first match.
// Optional self-check against the expected A operand is enabled by defining CMP_SCAN_SELFCHECK_EN.
module cmp_scan_driver #(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] base,
   input  logic [7:0] limit,
   output logic [7:0] probe,
   output logic       cmp_en_n,
   input  logic       cmp_neq,
   input  logic [7:0] target,
   output logic       busy,
   output logic       done,
   output logic       found,
   output logic [7:0] match_idx,
   output logic       mismatch_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // Counter runs SETTLE-1 down to 0; zero marks the sample cycle.
   localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

   state_t     state, state_nxt;
   logic [7:0] probe_nxt;
   logic [7:0] lim, lim_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       found_nxt;
   logic [7:0] idx_nxt;
   logic       sample;

   assign sample = (state == S_SETTLE) && (cnt == 4'd0);

`ifdef CMP_SCAN_SELFCHECK_EN
   logic err_q, err_nxt;
`endif

   // NOTE: every signal written here gets a default first, otherwise the unassigned paths infer latches.
   always_comb begin
      state_nxt = state;
      probe_nxt = probe;
      lim_nxt   = lim;
      cnt_nxt   = cnt;
      found_nxt = found;
      idx_nxt   = match_idx;
`ifdef CMP_SCAN_SELFCHECK_EN
      err_nxt   = err_q;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               lim_nxt   = limit;
               probe_nxt = base;
               found_nxt = 1'b0;
               idx_nxt   = 8'h00;
`ifdef CMP_SCAN_SELFCHECK_EN
               err_nxt   = 1'b0;
`endif
               cnt_nxt   = CNT_LOAD;
               state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (sample) begin
`ifdef CMP_SCAN_SELFCHECK_EN
               if ((probe != target) != cmp_neq) err_nxt = 1'b1;
`endif
               if (!cmp_neq) begin
                  found_nxt = 1'b1;
                  idx_nxt   = probe;
                  state_nxt = S_DONE;
               end else if (probe == lim) begin
                  found_nxt = 1'b0;
                  state_nxt = S_DONE;
               end else begin
                  probe_nxt = probe + 8'd1;
                  cnt_nxt   = CNT_LOAD;
               end
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         probe     <= 8'h00;
         lim       <= 8'h00;
         cnt       <= 4'd0;
         found     <= 1'b0;
         match_idx <= 8'h00;
      end else begin
         probe     <= probe_nxt;
         lim       <= lim_nxt;
         cnt       <= cnt_nxt;
         found     <= found_nxt;
         match_idx <= idx_nxt;
      end
   end

`ifdef CMP_SCAN_SELFCHECK_EN
   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_nxt;
   end
   assign mismatch_err = err_q;
`else
   logic unused_target;
   assign unused_target = ^target;
   assign mismatch_err  = 1'b0;
`endif

   assign busy     = (state == S_SETTLE);
   assign cmp_en_n = (state != S_SETTLE);
   assign done     = (state == S_DONE);

endmodule

// File: tb/tb_cmp_scan_driver.sv
// Self-checking bench for cmp_scan_driver with a behavioural 74F521-style comparator model.
// Expected scan results are queued at start and compared when done pulses.
module tb_cmp_scan_driver;

   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [7:0] base, limit, target;
   logic [7:0] probe, match_idx;
   logic       cmp_en_n, cmp_neq, busy, done, found, mismatch_err;
   logic       force_eq;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      logic       found;
      logic [7:0] idx;
      logic [7:0] last_probe;
      int         latency;
      int         t;
   } exp_t;

   exp_t sb[$];

   cmp_scan_driver #(.SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .start(start), .base(base), .limit(limit),
      .probe(probe), .cmp_en_n(cmp_en_n), .cmp_neq(cmp_neq), .target(target),
      .busy(busy), .done(done), .found(found), .match_idx(match_idx),
      .mismatch_err(mismatch_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Comparator model: A=target, B=probe; force_eq fakes a false match at 0x12.
   always_comb begin
      if (cmp_en_n)                       cmp_neq = 1'b1;
      else if (force_eq && probe == 8'h12) cmp_neq = 1'b0;
      else                                 cmp_neq = (probe != target);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input logic [7:0] b, input logic [7:0] l, input logic [7:0] tg);
      exp_t e;
      logic [7:0] p = b;
      e.found = 1'b0;
      e.idx   = 8'h00;
      for (int n = 1; n <= 256; n++) begin
         e.last_probe = p;
         e.latency    = n * SETTLE + 1;
         if (p == tg) begin
            e.found = 1'b1;
            e.idx   = p;
            break;
         end
         if (p == l) break;
         p = p + 8'd1;
      end
      return e;
   endfunction

   task automatic run_scan(input string tag, input logic [7:0] b, input logic [7:0] l,
                           input logic [7:0] tg, input exp_t e, input bit poke);
      exp_t got;
      bit   seen = 0;
      base   = b;
      limit  = l;
      target = tg;
      e.t    = cyc;
      sb.push_back(e);
      start  = 1'b1;
      step();
      start  = 1'b0;
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_en_n"}, cmp_en_n, 1'b0);
      check({tag, "_probe0"}, probe, b);
      base  = ~b;
      limit = ~l;
      if (poke) begin
         start = 1'b1;
         step();
         start = 1'b0;
      end
      for (int k = 0; k < 700; k++) begin
         if (done) begin
            seen = 1;
            break;
         end
         step();
      end
      check({tag, "_done_seen"}, seen, 1'b1);
      if (seen && sb.size() > 0) begin
         got = sb.pop_front();
         check({tag, "_latency"}, cyc - got.t, got.latency);
         check({tag, "_found"}, found, got.found);
         check({tag, "_match_idx"}, match_idx, got.idx);
         check({tag, "_probe_last"}, probe, got.last_probe);
         check({tag, "_done_en_n"}, cmp_en_n, 1'b1);
         check({tag, "_done_busy"}, busy, 1'b0);
         step();
         check({tag, "_done_pulse"}, done, 1'b0);
         check({tag, "_hold_found"}, found, got.found);
         check({tag, "_hold_idx"}, match_idx, got.idx);
      end
   endtask

   initial begin
      exp_t e;
      bit   saw_done;
      rst = 1'b1; start = 1'b0; base = 8'h00; limit = 8'h00; target = 8'h00; force_eq = 1'b0;
      step();
      step();
      check("rst_probe", probe, 8'h00);
      check("rst_en_n", cmp_en_n, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_found", found, 1'b0);
      check("rst_idx", match_idx, 8'h00);
      check("rst_err", mismatch_err, 1'b0);
      rst = 1'b0;
      step();

      // 1. Basic hit: expect done at t+11, match 0x14
      e = model(8'h10, 8'h1F, 8'h14);
      check("hit_model_lat", e.latency, 11);
      run_scan("hit", 8'h10, 8'h1F, 8'h14, e, 0);
      check("hit_err", mismatch_err, 1'b0);

      // 2. Miss across the range: done at t+33, probe stays at limit
      run_scan("miss", 8'h10, 8'h1F, 8'h30, model(8'h10, 8'h1F, 8'h30), 0);

      // 3. Wrap FE, FF, 00
      run_scan("wrap", 8'hFE, 8'h01, 8'h00, model(8'hFE, 8'h01, 8'h00), 0);

      // 4. Single-value scans, second one with a start pulse during busy
      run_scan("single_hit", 8'h55, 8'h55, 8'h55, model(8'h55, 8'h55, 8'h55), 0);
      run_scan("single_miss", 8'h55, 8'h55, 8'hAA, model(8'h55, 8'h55, 8'hAA), 1);
      for (int i = 0; i < 3; i++) begin
         check("norequeue_busy", busy, 1'b0);
         check("norequeue_done", done, 1'b0);
         step();
      end

      // 5. Reset mid-scan at cycle t+5
      base = 8'h00; limit = 8'hFF; target = 8'h80;
      start = 1'b1;
      step();
      start = 1'b0;
      saw_done = 0;
      for (int i = 0; i < 4; i++) begin
         saw_done |= done;
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      saw_done |= done;
      check("midrst_no_done", saw_done, 1'b0);
      check("midrst_probe", probe, 8'h00);
      check("midrst_en_n", cmp_en_n, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_found", found, 1'b0);
      check("midrst_idx", match_idx, 8'h00);
      run_scan("after_rst", 8'h20, 8'h28, 8'h23, model(8'h20, 8'h28, 8'h23), 0);

      // 6. Faked match at 0x12 while target is 0x14
      force_eq = 1'b1;
      e.found = 1'b1; e.idx = 8'h12; e.last_probe = 8'h12; e.latency = 3 * SETTLE + 1;
      run_scan("selfchk", 8'h10, 8'h1F, 8'h14, e, 0);
`ifdef CMP_SCAN_SELFCHECK_EN
      check("selfchk_err", mismatch_err, 1'b1);
`else
      check("selfchk_err", mismatch_err, 1'b0);
`endif
      force_eq = 1'b0;

      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmp_scan_driver.md
Name: cmp_scan_driver

Overview:
Initiator side of an 8-bit inverting equality comparator (74F521-style: output high = "not equal or disabled", active-low enable). Steps a probe byte across a programmed range onto the comparator's B operand, holds each value for a settle time, samples the comparator output and reports the first matching value. Used in the TTL simulation environment as a search/breakpoint sequencer in front of a comparator model.

Parameters:
SETTLE, 2, cycles each probe value is held before cmp_neq is sampled; legal range 1..15.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a scan; accepted only in IDLE
base  input  8  first probe value, latched at start acceptance
limit  input  8  last probe value, latched at start acceptance
probe  output  8  value driven to comparator B operand
cmp_en_n  output  1  comparator enable, active-low
cmp_neq  input  1  comparator output; 0 = equal, 1 = not equal or disabled
target  input  8  expected A operand; used only with the optional feature
busy  output  1  scan in progress
done  output  1  one-cycle pulse at scan end
found  output  1  last scan found a match
match_idx  output  8  matching probe value; valid when found=1
mismatch_err  output  1  self-check failure flag (optional feature)

Behaviour:
- Single clock domain; reset synchronous, active-high. It is sampled on the clk rising edge and overrides all other inputs.
- Reset values: probe=0x00, cmp_en_n=1, busy=0, done=0, found=0, match_idx=0x00, mismatch_err=0. The state machine enters IDLE.
- States: IDLE, SETTLE, DONE.
- IDLE, start=1 at the edge ending cycle t:
  - latch base and limit; clear found, match_idx and mismatch_err;
  - probe=base, cmp_en_n=0, busy=1 from cycle t+1;
  - load the settle counter and go to SETTLE.
- SETTLE:
  - count SETTLE cycles per probe value;
  - on the last of those cycles, sample cmp_neq at the closing edge.
  - cmp_neq=0: found=1, match_idx=probe, go to DONE.
  - cmp_neq=1 and probe==latched limit: found=0, go to DONE.
  - Otherwise: probe=probe+1 (mod 256), reload the counter, stay in SETTLE.
- DONE: lasts exactly one cycle with done=1, busy=0, cmp_en_n=1. probe holds the last value. Next state is IDLE.
- found and match_idx hold from DONE until the next accepted start or reset.
- Latency: the N-th candidate is sampled at the edge ending cycle t+N*SETTLE. done is high during cycle t+N*SETTLE+1.
- Range rules:
  - base==limit: exactly one compare.
  - limit<base: wrap, scanning base..0xFF then 0x00..limit.
  - base==limit+1 (mod 256): full 256-value scan.
  - The scan never exceeds 256 compares.
- start while busy or in DONE: ignored, with no queuing. base and limit changes during a scan are ignored.
- rst mid-scan: the scan is aborted and outputs take reset values on the next edge. done does not pulse.
- cmp_neq is ignored outside the sample cycle.

Optional Feature:
CMP_SCAN_SELFCHECK_EN
- Defined: at each sample edge the block computes ref = (probe != target).
  - If ref differs from cmp_neq, mismatch_err is set.
  - mismatch_err is sticky until the next accepted start or reset.
  - Scan result still follows cmp_neq.
- Undefined: mismatch_err is tied to 0, target is unused, and no compare logic is built.

Test Plan:
All scenarios use SETTLE=2 and a bench comparator model with A=target, B=probe and en=cmp_en_n.
1. Basic hit: base=0x10, limit=0x1F, target=0x14, start at t -> done in t+11, found=1, match_idx=0x14, cmp_en_n=1 in DONE.
2. Miss: base=0x10, limit=0x1F, target=0x30 -> done in t+33, found=0, probe=0x1F.
3. Wrap: base=0xFE, limit=0x01, target=0x00 -> probes FE, FF, 00; done in t+7; found=1, match_idx=0x00.
4. Single value and no-requeue: base=limit=0x55, target=0x55 -> done in t+3, found=1. Then base=limit=0x55 with target=0xAA -> done in t+3, found=0. A start pulsed during busy is not queued: busy=0 and done=0 in t+4..t+6.
5. Reset mid-scan: scan 0x00..0xFF, rst at t+5 -> cycle t+6 shows all reset values, no done. A new start is then accepted and completes normally.
6. Self-check: with the macro defined, the model forces cmp_neq=0 at probe 0x12 while target=0x14 -> found=1, match_idx=0x12, mismatch_err=1. With the macro undefined, mismatch_err=0.
